// File: rtl/jtopl_pkg.sv
// Shared OPL constants and the slot-to-operator decode used by the accumulator sequencer.
package jtopl_pkg;

   localparam int SLOTS_PER_FRAME = 18;
   localparam int CHANNELS        = 9;
   localparam int RHY_BD          = 6;
   localparam int RHY_SD_HH       = 7;
   localparam int RHY_TOM_CY      = 8;

   typedef struct packed {
      logic       op;
      logic [3:0] ch;
   } slot_dec_t;

   // Slots come in groups of six: three modulators then the three matching carriers.
   function automatic slot_dec_t slot_decode(input logic [4:0] slot);
      slot_dec_t  d;
      logic [4:0] g;
      logic [4:0] i;
      g    = slot / 5'd6;
      i    = slot % 5'd6;
      d.op = (i >= 5'd3);
      d.ch = 4'((g * 5'd3) + (d.op ? (i - 5'd3) : i));
      return d;
   endfunction

endpackage

// File: rtl/jtopl_acc_dly.sv
// cenop-gated shift register aligning issue-side enables with op_result at the accumulator.
module jtopl_acc_dly #(
   parameter int DELAY = 2,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cen,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   generate
      if (DELAY == 0) begin : g_direct
         assign dout = din;
      end else begin : g_shift
         logic [DELAY-1:0][W-1:0] dly_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dly_q <= '0;
            end else if (cen) begin
               dly_q[0] <= din;
               for (int k = 1; k < DELAY; k++) begin
                  dly_q[k] <= dly_q[k-1];
               end
            end
         end

         assign dout = dly_q[DELAY-1];
      end
   endgenerate

endmodule

// File: rtl/jtopl_acc_seq.sv
// Slot sequencer and sum/zero scheduler for the OPL output accumulator, with
// frame-synchronous connection and rhythm configuration.
module jtopl_acc_seq
   import jtopl_pkg::*;
#(
   parameter int SLOTS = SLOTS_PER_FRAME,
   parameter int DELAY = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cenop,
   input  logic       con_we,
   input  logic [3:0] con_ch,
   input  logic       con_din,
   input  logic       rhy_we,
   input  logic       rhy_din,
   output logic [4:0] slot,
   output logic       op,
   output logic [3:0] ch,
   output logic       sum_en,
   output logic       zero,
   output logic       sample_stb
);

   logic [4:0]          slot_q, slot_d;
   logic [CHANNELS-1:0] con_sh_q, con_sh_d, con_act_q;
   logic                rhy_sh_q, rhy_sh_d, rhy_act_q;
   logic                stb_q;
   logic                frame_end;
   logic                sum_p0, zero_p0;
   logic [1:0]          dly_out;
   slot_dec_t           dec;

   assign dec       = slot_decode(slot_q);
   assign frame_end = cenop && (slot_q == 5'(SLOTS - 1));

   always_comb begin
      slot_d = slot_q;
      if (cenop) begin
         slot_d = frame_end ? 5'd0 : slot_q + 5'd1;
      end
   end

   // Shadow registers accept writes on any clock; channels above 8 are dropped.
   always_comb begin
      con_sh_d = con_sh_q;
      rhy_sh_d = rhy_sh_q;
      if (con_we && (con_ch < 4'(CHANNELS))) begin
         con_sh_d[con_ch] = con_din;
      end
      if (rhy_we) begin
         rhy_sh_d = rhy_din;
      end
   end

   // Stage p0: issue-side enables for the slot entering the operator pipe
   always_comb begin
      zero_p0 = (slot_q == 5'd0);
      sum_p0  = dec.op | con_act_q[dec.ch];
      if (rhy_act_q) begin
         if (dec.ch == 4'(RHY_BD)) begin
            sum_p0 = dec.op;
         end else if ((dec.ch == 4'(RHY_SD_HH)) || (dec.ch == 4'(RHY_TOM_CY))) begin
            sum_p0 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q    <= '0;
         con_sh_q  <= '0;
         con_act_q <= '0;
         rhy_sh_q  <= 1'b0;
         rhy_act_q <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         con_sh_q <= con_sh_d;
         rhy_sh_q <= rhy_sh_d;
         if (frame_end) begin
            con_act_q <= con_sh_q;
            rhy_act_q <= rhy_sh_q;
         end
         stb_q <= cenop & zero;
      end
   end

   // Stage p0 -> accumulator: DELAY cenop ticks of alignment
   jtopl_acc_dly #(
      .DELAY (DELAY),
      .W     (2)
   ) u_dly (
      .clk  (clk),
      .rst  (rst),
      .cen  (cenop),
      .din  ({zero_p0, sum_p0}),
      .dout (dly_out)
   );

   assign slot       = slot_q;
   assign op         = dec.op;
   assign ch         = dec.ch;
   assign zero       = dly_out[1];
   assign sum_en     = dly_out[0];
   assign sample_stb = stb_q;

endmodule

// File: tb/tb_jtopl_acc_seq.sv
// Self-checking bench for jtopl_acc_seq: decode table, enable scoreboard and a dummy accumulator.
module tb_jtopl_acc_seq;

   localparam int DELAY = 2;
   localparam int SLOTS = 18;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cenop = 1'b0;
   logic       con_we = 1'b0;
   logic [3:0] con_ch = 4'd0;
   logic       con_din = 1'b0;
   logic       rhy_we = 1'b0;
   logic       rhy_din = 1'b0;
   logic [4:0] slot;
   logic       op;
   logic [3:0] ch;
   logic       sum_en;
   logic       zero;
   logic       sample_stb;

   jtopl_acc_seq #(.SLOTS(SLOTS), .DELAY(DELAY)) dut (
      .clk(clk), .rst(rst), .cenop(cenop),
      .con_we(con_we), .con_ch(con_ch), .con_din(con_din),
      .rhy_we(rhy_we), .rhy_din(rhy_din),
      .slot(slot), .op(op), .ch(ch),
      .sum_en(sum_en), .zero(zero), .sample_stb(sample_stb)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      bit op;
      int ch;
   } dec_t;

   dec_t     dec_tab[18];
   int       n_chk = 0;
   int       n_pass = 0;
   bit [1:0] exp_q[$];
   int       hist_q[$];
   int       zero_ticks[$];
   int       m_slot;
   bit [8:0] m_con_sh, m_con_act;
   bit       m_rhy_sh, m_rhy_act, m_stb;
   int       tk, cyc_n, cnt_sum, last_stb, n_snd;
   int       acc, snd, exp_snd;
   bit       acc_chk;
   int       cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic bit m_sum(input int s, input bit [8:0] con, input bit rhy);
      int c;
      bit o;
      o = (s % 6) >= 3;
      c = (s / 6) * 3 + (s % 3);
      if (rhy && c == 6) return o;
      if (rhy && c >= 7) return 1'b1;
      return o | con[c];
   endfunction

   function automatic int frame_sum(input bit [8:0] con, input bit rhy);
      int t;
      t = 0;
      for (int s = 0; s < SLOTS; s++) if (m_sum(s, con, rhy)) t += s + 1;
      return t;
   endfunction

   // One clock: compare pre-edge outputs with the model, then advance both.
   task automatic cyc(input bit cen);
      bit [1:0] ex;
      bit [1:0] iss;
      int       res;
      iss = 2'b00;
      cenop = cen;
      ex = exp_q[0];
      chk("sum_en", 32'(sum_en), 32'(ex[0]));
      chk("zero", 32'(zero), 32'(ex[1]));
      chk("slot", 32'(slot), 32'(m_slot));
      chk("sample_stb", 32'(sample_stb), 32'(m_stb));
      if (cen) begin
         res = hist_q[0] + 1;
         hist_q.push_back(int'(slot));
         void'(hist_q.pop_front());
         if (zero === 1'b1) begin
            snd = acc;
            acc = (sum_en === 1'b1) ? res : 0;
            zero_ticks.push_back(tk);
         end else if (sum_en === 1'b1) begin
            acc += res;
         end
         if (sum_en === 1'b1) cnt_sum++;
         iss = {m_slot == 0, m_sum(m_slot, m_con_act, m_rhy_act)};
      end
      if (sample_stb === 1'b1) begin
         if (acc_chk) begin
            chk("snd", 32'(snd), 32'(exp_snd));
            chk("stb_gap", 32'(cyc_n - last_stb), 32'(4 * SLOTS));
            n_snd++;
         end
         last_stb = cyc_n;
      end
      @(posedge clk);
      #1;
      m_stb = cen & ex[1];
      if (cen) begin
         exp_q.push_back(iss);
         void'(exp_q.pop_front());
         if (m_slot == SLOTS - 1) begin
            m_con_act = m_con_sh;
            m_rhy_act = m_rhy_sh;
            m_slot = 0;
         end else begin
            m_slot++;
         end
         tk++;
      end
      if (con_we && con_ch < 9) m_con_sh[con_ch] = con_din;
      if (rhy_we) m_rhy_sh = rhy_din;
      con_we = 1'b0;
      rhy_we = 1'b0;
      cenop = 1'b0;
      cyc_n++;
   endtask

   task automatic do_reset(input int hold);
      cenop = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_slot", 32'(slot), 32'd0);
      chk("rst_sum_en", 32'(sum_en), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_stb", 32'(sample_stb), 32'd0);
      repeat (hold) @(posedge clk);
      #1;
      rst = 1'b0;
      m_slot = 0;
      m_con_sh = '0;
      m_con_act = '0;
      m_rhy_sh = 1'b0;
      m_rhy_act = 1'b0;
      m_stb = 1'b0;
      exp_q.delete();
      hist_q.delete();
      for (int k = 0; k < DELAY; k++) begin
         exp_q.push_back(2'b00);
         hist_q.push_back(0);
      end
      zero_ticks.delete();
      acc = 0;
      snd = 0;
      tk = 0;
      last_stb = -1000;
      acc_chk = 1'b0;
   endtask

   task automatic to_slot(input int s);
      for (int k = 0; k < SLOTS && m_slot != s; k++) cyc(1'b1);
   endtask

   // Counts sum_en over the 18 delayed ticks that belong to one whole frame.
   task automatic run_frame(output int c);
      to_slot(DELAY);
      cnt_sum = 0;
      repeat (SLOTS) cyc(1'b1);
      c = cnt_sum;
   endtask

   initial begin
      dec_tab = '{'{0, 0, 0}, '{1, 0, 1}, '{2, 0, 2}, '{3, 1, 0}, '{4, 1, 1}, '{5, 1, 2},
                  '{6, 0, 3}, '{7, 0, 4}, '{8, 0, 5}, '{9, 1, 3}, '{10, 1, 4}, '{11, 1, 5},
                  '{12, 0, 6}, '{13, 0, 7}, '{14, 0, 8}, '{15, 1, 6}, '{16, 1, 7}, '{17, 1, 8}};
      cyc_n = 0;
      n_snd = 0;
      cnt_sum = 0;
      do_reset(2);

      // 1: default config, decode order, zero timing and carrier-only summing
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < SLOTS; k++) begin
            chk("dec_slot", 32'(slot), 32'(dec_tab[k].s));
            chk("dec_op", 32'(op), 32'(dec_tab[k].op));
            chk("dec_ch", 32'(ch), 32'(dec_tab[k].ch));
            cyc(1'b1);
         end
      end
      chk("zero_count", 32'(zero_ticks.size()), 32'd2);
      chk("zero_tick0", 32'((zero_ticks.size() > 0) ? zero_ticks[0] : -1), 32'd2);
      chk("zero_tick1", 32'((zero_ticks.size() > 1) ? zero_ticks[1] : -1), 32'd20);
      run_frame(cnt);
      chk("sum_cnt_default", 32'(cnt), 32'd9);

      // 2: mid-frame connection write on a clock without cenop
      to_slot(8);
      con_we = 1'b1; con_ch = 4'd4; con_din = 1'b1;
      cyc(1'b0);
      run_frame(cnt);
      chk("sum_cnt_ch4_add", 32'(cnt), 32'd10);

      // 3: simultaneous clear of ch4 and rhythm enable, plus an ignored channel write
      con_we = 1'b1; con_ch = 4'd4; con_din = 1'b0; rhy_we = 1'b1; rhy_din = 1'b1;
      cyc(1'b1);
      con_we = 1'b1; con_ch = 4'd12; con_din = 1'b1;
      cyc(1'b0);
      repeat (SLOTS) cyc(1'b1);
      run_frame(cnt);
      chk("sum_cnt_rhythm", 32'(cnt), 32'd11);

      // 4: write landing on the exact frame-boundary clock
      to_slot(SLOTS - 1);
      con_we = 1'b1; con_ch = 4'd0; con_din = 1'b1;
      cyc(1'b1);
      run_frame(cnt);
      chk("sum_cnt_bnd_old", 32'(cnt), 32'd11);
      run_frame(cnt);
      chk("sum_cnt_bnd_new", 32'(cnt), 32'd12);

      // 5: asynchronous reset mid-frame
      to_slot(9);
      chk("pre_rst_slot", 32'(slot), 32'd9);
      do_reset(3);
      repeat (22) cyc(1'b1);
      chk("post_rst_zero", 32'((zero_ticks.size() > 0) ? zero_ticks[0] : -1), 32'(DELAY));

      // 6: cenop 1-in-4 with accumulator and sample strobe
      do_reset(1);
      con_we = 1'b1; con_ch = 4'd0; con_din = 1'b1; rhy_we = 1'b1; rhy_din = 1'b1;
      cyc(1'b0);
      con_we = 1'b1; con_ch = 4'd4; con_din = 1'b1;
      cyc(1'b0);
      con_we = 1'b1; con_ch = 4'd8; con_din = 1'b1;
      cyc(1'b0);
      exp_snd = frame_sum(9'b1_0001_0001, 1'b1);
      n_snd = 0;
      for (int t = 0; t < 5 * SLOTS * 4; t++) begin
         acc_chk = (t >= 3 * SLOTS * 4);
         cyc((t % 4) == 0);
      end
      acc_chk = 1'b0;
      chk("snd_checks", 32'(n_snd), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
